mem_stage: RTL and testbench

- MEM stage of the 16-bit pipelined CPU; sits between EX and the writeback stage.
- Holds the EX/MEM pipeline register.
- Runs the data-memory request/ready handshake, stalls the upstream pipeline while an access is outstanding, and provides a forwarding path for the in-flight result.
- Writeback registers this block's outputs at every posedge.

---
 rtl/mem_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM stage of the 16-bit pipelined CPU.
//
// Holds the EX/MEM pipeline register, runs the data-memory request/ready
// handshake, freezes the upstream pipeline while an access is outstanding,
// and offers a forwarding path for the result of the held instruction.
// Writeback outputs are combinational views of the held instruction; the
// writeback stage registers them.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   Pc, ALUOut, StoreData         EX results (PC+1, ALU result/address, store data)
//   RegWriteTarget, RegWriteSrc   destination register, result source (0 ALU, 1 mem, 2 PC)
//   MemRead, MemWrite, RegWrite   control for the instruction leaving EX
//   d_ready, d_rdata              memory completion and load data
//   d_readM, d_writeM             memory read / write requests
//   d_address, d_wdata            memory address / store data
//   Stall_OUT                     freeze PC, IF/ID, ID/EX, EX/MEM
//   Pc_OUT, ALUOut_OUT, MemData_OUT, RegWriteTarget_OUT,
//   RegWriteSrc_OUT, RegWrite_OUT to writeback
//   FwdValid, FwdTarget, FwdData  forwarding of the in-flight result
//
// Optional build macro MEM_STAGE_PERF_EN adds saturating counters
// MemAccessCount (completed accesses) and MemStallCount (stall cycles).
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] Pc,
  input  logic [WORD_SIZE-1:0] ALUOut,
  input  logic [WORD_SIZE-1:0] StoreData,
  input  logic [1:0]           RegWriteTarget,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           RegWriteSrc,
  input  logic                 RegWrite,
  input  logic                 d_ready,
  input  logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [WORD_SIZE-1:0] d_wdata,
  output logic                 Stall_OUT,
  output logic [WORD_SIZE-1:0] Pc_OUT,
  output logic [WORD_SIZE-1:0] ALUOut_OUT,
  output logic [WORD_SIZE-1:0] MemData_OUT,
  output logic [1:0]           RegWriteTarget_OUT,
  output logic [1:0]           RegWriteSrc_OUT,
  output logic                 RegWrite_OUT,
  output logic                 FwdValid,
  output logic [1:0]           FwdTarget,
  output logic [WORD_SIZE-1:0] FwdData
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] MemAccessCount,
  output logic [CNT_WIDTH-1:0] MemStallCount
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // A counter narrower than one bit is not a meaningful configuration.
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
  end

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] alu_out_q, alu_out_d;
  logic [WORD_SIZE-1:0] store_data_q, store_data_d;
  logic [1:0]           rw_target_q, rw_target_d;
  logic [1:0]           rw_src_q, rw_src_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 reg_write_q, reg_write_d;

  logic                 in_access;
  logic                 access_done;
  logic                 stall;

  assign in_access   = (state_q == ACCESS);
  assign access_done = in_access & d_ready;
  assign stall       = in_access & ~d_ready;

  // Next-state logic for the EX/MEM register and handshake state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    alu_out_d    = alu_out_q;
    store_data_d = store_data_q;
    rw_target_d  = rw_target_q;
    rw_src_d     = rw_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    if (!stall) begin
      pc_d         = Pc;
      alu_out_d    = ALUOut;
      store_data_d = StoreData;
      rw_target_d  = RegWriteTarget;
      rw_src_d     = RegWriteSrc;
      mem_read_d   = MemRead;
      // A simultaneous read and write is executed as a load only.
      mem_write_d  = MemWrite & ~MemRead;
      reg_write_d  = RegWrite;
      state_d      = (MemRead | MemWrite) ? ACCESS : IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // EX/MEM pipeline register and state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= {WORD_SIZE{1'b0}};
      alu_out_q    <= {WORD_SIZE{1'b0}};
      store_data_q <= {WORD_SIZE{1'b0}};
      rw_target_q  <= 2'd0;
      rw_src_q     <= 2'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      alu_out_q    <= alu_out_d;
      store_data_q <= store_data_d;
      rw_target_q  <= rw_target_d;
      rw_src_q     <= rw_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Memory request, writeback and forwarding outputs.
  always_comb begin
    d_readM            = in_access & mem_read_q;
    d_writeM           = in_access & mem_write_q;
    d_address          = in_access ? alu_out_q : {WORD_SIZE{1'b0}};
    d_wdata            = in_access ? store_data_q : {WORD_SIZE{1'b0}};
    Stall_OUT          = stall;
    Pc_OUT             = pc_q;
    ALUOut_OUT         = alu_out_q;
    RegWriteTarget_OUT = rw_target_q;
    RegWriteSrc_OUT    = rw_src_q;
    MemData_OUT        = access_done ? d_rdata : {WORD_SIZE{1'b0}};
    // A stalled cycle reaches writeback as a bubble.
    RegWrite_OUT       = reg_write_q & ~stall;
    FwdTarget          = rw_target_q;
    // Memory-sourced results are only forwardable in the completing cycle.
    FwdValid           = reg_write_q & ((rw_src_q != 2'd1) | access_done);
    case (rw_src_q)
      2'd0:    FwdData = alu_out_q;
      2'd1:    FwdData = d_rdata;
      2'd2:    FwdData = pc_q;
      2'd3:    FwdData = {WORD_SIZE{1'b0}};
      default: FwdData = {WORD_SIZE{1'b0}};
    endcase
  end

`ifdef MEM_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating increments of the performance counters.
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (access_done && (acc_cnt_q != {CNT_WIDTH{1'b1}})) begin
      acc_cnt_d = acc_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
    if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q   <= {CNT_WIDTH{1'b0}};
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemAccessCount = acc_cnt_q;
  assign MemStallCount  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Writeback results are queued when an
// instruction is issued and compared when the stage presents RegWrite_OUT=1.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] Pc, ALUOut, StoreData, d_rdata;
  logic [1:0]  RegWriteTarget, RegWriteSrc;
  logic        MemRead, MemWrite, RegWrite, d_ready;
  logic        d_readM, d_writeM, Stall_OUT, RegWrite_OUT, FwdValid;
  logic [15:0] d_address, d_wdata, Pc_OUT, ALUOut_OUT, MemData_OUT, FwdData;
  logic [1:0]  RegWriteTarget_OUT, RegWriteSrc_OUT, FwdTarget;
`ifdef MEM_STAGE_PERF_EN
  logic [15:0] MemAccessCount, MemStallCount;
`endif

  typedef struct packed {
    logic [1:0]  src;
    logic [1:0]  tgt;
    logic [15:0] val;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .Pc(Pc), .ALUOut(ALUOut), .StoreData(StoreData),
    .RegWriteTarget(RegWriteTarget), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWriteSrc(RegWriteSrc), .RegWrite(RegWrite), .d_ready(d_ready), .d_rdata(d_rdata),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .Stall_OUT(Stall_OUT), .Pc_OUT(Pc_OUT), .ALUOut_OUT(ALUOut_OUT),
    .MemData_OUT(MemData_OUT), .RegWriteTarget_OUT(RegWriteTarget_OUT),
    .RegWriteSrc_OUT(RegWriteSrc_OUT), .RegWrite_OUT(RegWrite_OUT),
    .FwdValid(FwdValid), .FwdTarget(FwdTarget), .FwdData(FwdData)
`ifdef MEM_STAGE_PERF_EN
    , .MemAccessCount(MemAccessCount), .MemStallCount(MemStallCount)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_bubble();
    Pc = 16'h0000; ALUOut = 16'h0000; StoreData = 16'h0000;
    RegWriteTarget = 2'd0; RegWriteSrc = 2'd0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
  endtask

  task automatic issue(input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [1:0] tgt, input logic [1:0] src,
                       input logic mr, input logic mw, input logic rw);
    Pc = pc; ALUOut = alu; StoreData = sd; RegWriteTarget = tgt; RegWriteSrc = src;
    MemRead = mr; MemWrite = mw; RegWrite = rw;
  endtask

  task automatic test_reset();
    set_bubble(); d_ready = 1'b0; d_rdata = 16'h0000;
    #2;
    n_cmp++; if (d_readM !== 1'b0) begin n_bad++; $display("FAIL reset_readM: got %b expected 0", d_readM); end
    n_cmp++; if (d_writeM !== 1'b0) begin n_bad++; $display("FAIL reset_writeM: got %b expected 0", d_writeM); end
    n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", Stall_OUT); end
    n_cmp++; if (RegWrite_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite_OUT); end
    n_cmp++; if (FwdValid !== 1'b0) begin n_bad++; $display("FAIL reset_fwdvalid: got %b expected 0", FwdValid); end
    n_cmp++; if ({Pc_OUT, ALUOut_OUT, MemData_OUT, FwdData} !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {Pc_OUT, ALUOut_OUT, MemData_OUT, FwdData}); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_alu_op();
    wb_t e;
    @(negedge clk);
    issue(16'h0005, 16'h1234, 16'h0000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);
    sb_q.push_back('{src: 2'd0, tgt: 2'd2, val: 16'h1234});
    #1;
    n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b expected 0", Stall_OUT); end
    @(negedge clk); set_bubble(); #1;
    n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL alu_stall2: got %b expected 0", Stall_OUT); end
    n_cmp++; if (RegWrite_OUT !== 1'b1) begin n_bad++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite_OUT); end
    else if (sb_q.size() == 0) begin n_bad++; $display("FAIL alu_sb: got empty expected entry"); end
    else begin
      e = sb_q.pop_front();
      n_cmp++; if ({RegWriteTarget_OUT, ALUOut_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL alu_wb: got %h expected %h", {RegWriteTarget_OUT, ALUOut_OUT}, {e.tgt, e.val}); end
    end
    n_cmp++; if ({FwdValid, FwdTarget, FwdData} !== {1'b1, 2'd2, 16'h1234}) begin n_bad++; $display("FAIL alu_fwd: got %h expected %h", {FwdValid, FwdTarget, FwdData}, {1'b1, 2'd2, 16'h1234}); end
    n_cmp++; if (d_readM !== 1'b0) begin n_bad++; $display("FAIL alu_readM: got %b expected 0", d_readM); end
  endtask

  task automatic test_pc_src();
    wb_t e;
    @(negedge clk);
    issue(16'h0077, 16'h9999, 16'h0000, 2'd3, 2'd2, 1'b0, 1'b0, 1'b1);
    sb_q.push_back('{src: 2'd2, tgt: 2'd3, val: 16'h0077});
    @(negedge clk);
    issue(16'h0078, 16'h4444, 16'h0000, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1);
    sb_q.push_back('{src: 2'd3, tgt: 2'd1, val: 16'h4444});
    #1;
    n_cmp++; if ({FwdValid, FwdData} !== {1'b1, 16'h0077}) begin n_bad++; $display("FAIL pcsrc_fwd: got %h expected %h", {FwdValid, FwdData}, {1'b1, 16'h0077}); end
    if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++; if ({RegWriteTarget_OUT, RegWriteSrc_OUT, Pc_OUT} !== {e.tgt, e.src, e.val}) begin n_bad++; $display("FAIL pcsrc_wb: got %h expected %h", {RegWriteTarget_OUT, RegWriteSrc_OUT, Pc_OUT}, {e.tgt, e.src, e.val}); end
    end else begin n_cmp++; n_bad++; $display("FAIL pcsrc_regwrite: got %b expected 1", RegWrite_OUT); end
    @(negedge clk); set_bubble(); #1;
    n_cmp++; if ({FwdValid, FwdData} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL src3_fwd: got %h expected %h", {FwdValid, FwdData}, {1'b1, 16'h0000}); end
    if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++; if ({RegWriteTarget_OUT, ALUOut_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL src3_wb: got %h expected %h", {RegWriteTarget_OUT, ALUOut_OUT}, {e.tgt, e.val}); end
    end else begin n_cmp++; n_bad++; $display("FAIL src3_regwrite: got %b expected 1", RegWrite_OUT); end
  endtask

  task automatic test_load();
    wb_t  e;
    int   rd_cycles = 0;
    int   st_cycles = 0;
    logic exp_stall;
    @(negedge clk);
    issue(16'h0010, 16'h0040, 16'h0000, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    sb_q.push_back('{src: 2'd1, tgt: 2'd1, val: 16'hBEEF});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_bubble();
      d_ready = (i == 3);
      d_rdata = (i == 3) ? 16'hBEEF : 16'hDEAD;
      exp_stall = (i < 3);
      #1;
      if (d_readM === 1'b1 && d_address === 16'h0040) rd_cycles++;
      if (Stall_OUT === 1'b1) st_cycles++;
      n_cmp++; if (Stall_OUT !== exp_stall) begin n_bad++; $display("FAIL load_stall[%0d]: got %b expected %b", i, Stall_OUT, exp_stall); end
      if (exp_stall) begin
        n_cmp++; if ({RegWrite_OUT, FwdValid, MemData_OUT} !== 18'h0) begin n_bad++; $display("FAIL load_bubble[%0d]: got %h expected 0", i, {RegWrite_OUT, FwdValid, MemData_OUT}); end
      end else if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++; if ({RegWriteTarget_OUT, MemData_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL load_wb: got %h expected %h", {RegWriteTarget_OUT, MemData_OUT}, {e.tgt, e.val}); end
        n_cmp++; if ({FwdValid, FwdData} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL load_fwd: got %h expected %h", {FwdValid, FwdData}, {1'b1, 16'hBEEF}); end
      end else begin n_cmp++; n_bad++; $display("FAIL load_regwrite: got %b expected 1", RegWrite_OUT); end
    end
    n_cmp++; if (rd_cycles != 4) begin n_bad++; $display("FAIL load_req_cycles: got %0d expected 4", rd_cycles); end
    n_cmp++; if (st_cycles != 3) begin n_bad++; $display("FAIL load_stall_cycles: got %0d expected 3", st_cycles); end
    @(negedge clk); d_ready = 1'b0; #1;
    n_cmp++; if ({d_readM, Stall_OUT} !== 2'b00) begin n_bad++; $display("FAIL load_after: got %b expected 00", {d_readM, Stall_OUT}); end
  endtask

  task automatic test_store();
    @(negedge clk);
    issue(16'h0020, 16'h0010, 16'h00AA, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); set_bubble(); d_ready = 1'b1; d_rdata = 16'h0000; #1;
    n_cmp++; if ({d_writeM, d_readM, d_address, d_wdata} !== {1'b1, 1'b0, 16'h0010, 16'h00AA}) begin n_bad++; $display("FAIL store_req: got %h expected %h", {d_writeM, d_readM, d_address, d_wdata}, {1'b1, 1'b0, 16'h0010, 16'h00AA}); end
    n_cmp++; if ({Stall_OUT, RegWrite_OUT} !== 2'b00) begin n_bad++; $display("FAIL store_stall: got %b expected 00", {Stall_OUT, RegWrite_OUT}); end
    @(negedge clk); d_ready = 1'b0; #1;
    n_cmp++; if ({d_writeM, Stall_OUT} !== 2'b00) begin n_bad++; $display("FAIL store_after: got %b expected 00", {d_writeM, Stall_OUT}); end
  endtask

`ifdef MEM_STAGE_PERF_EN
  task automatic test_perf();
    n_cmp++; if (MemAccessCount !== 16'd2) begin n_bad++; $display("FAIL perf_access: got %0d expected 2", MemAccessCount); end
    n_cmp++; if (MemStallCount !== 16'd3) begin n_bad++; $display("FAIL perf_stall: got %0d expected 3", MemStallCount); end
  endtask
`endif

  task automatic test_both_mem();
    wb_t e;
    @(negedge clk);
    issue(16'h0030, 16'h0030, 16'h7777, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1);
    sb_q.push_back('{src: 2'd1, tgt: 2'd2, val: 16'hCAFE});
    @(negedge clk); set_bubble(); d_ready = 1'b1; d_rdata = 16'hCAFE; #1;
    n_cmp++; if ({d_readM, d_writeM, Stall_OUT} !== 3'b100) begin n_bad++; $display("FAIL both_req: got %b expected 100", {d_readM, d_writeM, Stall_OUT}); end
    if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++; if ({RegWriteTarget_OUT, MemData_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL both_wb: got %h expected %h", {RegWriteTarget_OUT, MemData_OUT}, {e.tgt, e.val}); end
    end else begin n_cmp++; n_bad++; $display("FAIL both_regwrite: got %b expected 1", RegWrite_OUT); end
  endtask

  task automatic test_ready_outside();
    wb_t e;
    @(negedge clk);
    issue(16'h0040, 16'h0ABC, 16'h0000, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
    d_ready = 1'b1; d_rdata = 16'h5555;
    sb_q.push_back('{src: 2'd0, tgt: 2'd3, val: 16'h0ABC});
    @(negedge clk); set_bubble(); #1;
    n_cmp++; if ({Stall_OUT, d_readM, MemData_OUT} !== 18'h0) begin n_bad++; $display("FAIL idle_ready: got %h expected 0", {Stall_OUT, d_readM, MemData_OUT}); end
    if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++; if ({RegWriteTarget_OUT, ALUOut_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL idle_wb: got %h expected %h", {RegWriteTarget_OUT, ALUOut_OUT}, {e.tgt, e.val}); end
    end else begin n_cmp++; n_bad++; $display("FAIL idle_regwrite: got %b expected 1", RegWrite_OUT); end
    @(negedge clk); d_ready = 1'b0; #1;
    n_cmp++; if ({RegWrite_OUT, Stall_OUT} !== 2'b00) begin n_bad++; $display("FAIL bubble_after: got %b expected 00", {RegWrite_OUT, Stall_OUT}); end
  endtask

  task automatic test_back_to_back();
    wb_t e;
    int  rd_cycles = 0;
    logic [15:0] exp_addr [4] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200};
    @(negedge clk);
    issue(16'h0050, 16'h0100, 16'h0000, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    sb_q.push_back('{src: 2'd1, tgt: 2'd1, val: 16'h1111});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 2) issue(16'h0051, 16'h0200, 16'h0000, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1);
      else set_bubble();
      d_ready = (i == 1) || (i == 3);
      d_rdata = (i == 1) ? 16'h1111 : ((i == 3) ? 16'h2222 : 16'hDEAD);
      if (i == 1) sb_q.push_back('{src: 2'd1, tgt: 2'd3, val: 16'h2222});
      #1;
      if (d_readM === 1'b1) rd_cycles++;
      n_cmp++; if (d_address !== exp_addr[i]) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, d_address, exp_addr[i]); end
      if (d_ready) begin
        if (RegWrite_OUT === 1'b1 && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          n_cmp++; if ({RegWriteTarget_OUT, MemData_OUT} !== {e.tgt, e.val}) begin n_bad++; $display("FAIL b2b_wb[%0d]: got %h expected %h", i, {RegWriteTarget_OUT, MemData_OUT}, {e.tgt, e.val}); end
        end else begin n_cmp++; n_bad++; $display("FAIL b2b_regwrite[%0d]: got %b expected 1", i, RegWrite_OUT); end
      end else begin
        n_cmp++; if ({Stall_OUT, RegWrite_OUT} !== 2'b10) begin n_bad++; $display("FAIL b2b_stall[%0d]: got %b expected 10", i, {Stall_OUT, RegWrite_OUT}); end
      end
    end
    n_cmp++; if (rd_cycles != 4) begin n_bad++; $display("FAIL b2b_req_cycles: got %0d expected 4", rd_cycles); end
    @(negedge clk); d_ready = 1'b0; #1;
    n_cmp++; if ({d_readM, sb_q.size() == 0} !== 2'b01) begin n_bad++; $display("FAIL b2b_after: got %b expected 01", {d_readM, sb_q.size() == 0}); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    issue(16'h0060, 16'h0050, 16'h0000, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); set_bubble(); d_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({d_readM, Stall_OUT} !== 2'b11) begin n_bad++; $display("FAIL midrst_pre: got %b expected 11", {d_readM, Stall_OUT}); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({d_readM, Stall_OUT, RegWrite_OUT} !== 3'b000) begin n_bad++; $display("FAIL midrst_drop: got %b expected 000", {d_readM, Stall_OUT, RegWrite_OUT}); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({d_readM, Stall_OUT, RegWrite_OUT, d_address} !== 19'h0) begin n_bad++; $display("FAIL midrst_idle: got %h expected 0", {d_readM, Stall_OUT, RegWrite_OUT, d_address}); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_pc_src();
    test_load();
    test_store();
`ifdef MEM_STAGE_PERF_EN
    test_perf();
`endif
    test_both_mem();
    test_ready_outside();
    test_back_to_back();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
